// File: rtl/div32_iter.sv
// rtl/div32_iter.sv - iterative restoring 32-bit divider, signed/unsigned, start/busy/done
module div32_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] qreg;     // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH:0]   prem;     // 33-bit partial remainder
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] r_src;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

  // One restoring step: shift remainder:dividend left, trial-subtract divisor.
  assign sh   = {prem, qreg[WIDTH-1]};
  assign diff = sh - {2'b00, dvs};

  // On divide-by-zero qreg still holds the dividend magnitude, so re-applying
  // the dividend sign returns the original dividend as the remainder.
  assign r_src = dz ? qreg : prem[WIDTH-1:0];
  assign q_fix = dz ? {WIDTH{1'b1}} : (q_neg ? (~qreg + 1'b1) : qreg);
  assign r_fix = r_neg ? (~r_src + 1'b1) : r_src;

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      qreg        <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            qreg  <= dvd_mag;
            dvs   <= dvs_mag;
            q_neg <= dvd_neg ^ dvs_neg;
            r_neg <= dvd_neg;
            prem  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (divisor == '0) begin
              dz    <= 1'b1;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (!diff[WIDTH+1]) begin
              prem <= diff[WIDTH:0];
              qreg <= {qreg[WIDTH-2:0], 1'b1};
            end else begin
              prem <= sh[WIDTH:0];
              qreg <= {qreg[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= dz;
            done        <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_iter.sv
// tb/tb_div32_iter.sv - directed self-checking bench for div32_iter
module tb_div32_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors;
  int errors;

  div32_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .flush       (flush),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept a start at the next rising edge, then count cycles to done (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/dz=%b%b%b need 000", busy, done, div_by_zero);
    end
    vectors++;
    if (quotient !== 32'h0 || remainder !== 32'h0) begin
      errors++;
      $display("FAIL reset_results: got q=%h r=%h need 0/0", quotient, remainder);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat;
    run_op(32'd100, 32'd7, 1'b0, lat);
    vectors++;
    if (lat !== 33) begin errors++; $display("FAIL u100_7_latency: got %0d need 33", lat); end
    vectors++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL u100_7: got q=%h r=%h dz=%b busy=%b need 0000000e/00000002/0/0",
               quotient, remainder, div_by_zero, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse: got done=%b need 0", done); end
  endtask

  task automatic test_signed;
    int lat;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    vectors++;
    if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL s_m7_2: got lat=%0d q=%h r=%h need 33/fffffffd/ffffffff", lat, quotient, remainder);
    end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
    vectors++;
    if (lat !== 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
      errors++;
      $display("FAIL s_7_m2: got lat=%0d q=%h r=%h need 33/fffffffd/00000001", lat, quotient, remainder);
    end
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, lat);
    vectors++;
    if (lat !== 33 || quotient !== 32'h7FFF_FFFC || remainder !== 32'd1) begin
      errors++;
      $display("FAIL u_fff9_2: got lat=%0d q=%h r=%h need 33/7ffffffc/00000001", lat, quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(32'd5, 32'd0, 1'b0, lat);
    vectors++;
    if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_5_0: got lat=%0d q=%h r=%h dz=%b need 1/ffffffff/00000005/1",
               lat, quotient, remainder, div_by_zero);
    end
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, lat);
    vectors++;
    if (lat !== 1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFFB || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_m5_0: got lat=%0d q=%h r=%h dz=%b need 1/ffffffff/fffffffb/1",
               lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_overflow;
    int lat;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    vectors++;
    if (lat !== 33 || quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL s_overflow: got lat=%0d q=%h r=%h dz=%b need 33/80000000/00000000/0",
               lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (10) begin @(negedge clk); lat++; end
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    vectors++;
    if (!done || lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++;
      $display("FAIL start_ignored: got done=%b lat=%0d q=%h r=%h need 1/33/0000000e/00000002",
               done, lat, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(32'd100, 32'd7, 1'b0, lat);
    dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got done=%b busy=%b need 0/1", done, busy);
    end
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    vectors++;
    if (!done || lat !== 33 || quotient !== 32'd3 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL b2b_9_3: got done=%b lat=%0d q=%h r=%h need 1/33/00000003/00000000",
               done, lat, quotient, remainder);
    end
  endtask

  task automatic test_flush;
    int lat;
    int seen;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got busy=%b need 0", busy); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    vectors++;
    if (seen !== 0 || quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold: got dones=%0d q=%h r=%h dz=%b need 0/00000003/00000000/0",
               seen, quotient, remainder, div_by_zero);
    end
    run_op(32'd50, 32'd5, 1'b0, lat);
    vectors++;
    if (lat !== 33 || quotient !== 32'd10 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL after_flush_50_5: got lat=%0d q=%h r=%h need 33/0000000a/00000000", lat, quotient, remainder);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    int seen;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b q=%h r=%h dz=%b need all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    vectors++;
    if (seen !== 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles need 0", seen); end
    run_op(32'd100, 32'd7, 1'b0, lat);
    vectors++;
    if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++;
      $display("FAIL post_reset_100_7: got lat=%0d q=%h r=%h need 33/0000000e/00000002", lat, quotient, remainder);
    end
  endtask

  initial begin
    vectors   = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    flush     = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_start_ignored;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
